// File: rtl/aurora_axi_tx_arb.sv
// Packet-atomic arbiter that merges CH_COUNT AXI-stream slave channels into one
// registered master stream, using either a fixed channel select or round-robin.
module aurora_axi_tx_arb #(
    parameter int CH_COUNT = 4,
    parameter int DATA_W   = 32,
    parameter int SEL_W    = 2,
    localparam int KEEP_W  = DATA_W / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    input  logic [CH_COUNT-1:0]          ch_mask,
    output logic [CH_COUNT-1:0]          axis_s_tready,
    input  logic [CH_COUNT*DATA_W-1:0]   axis_s_tdata,
    input  logic [CH_COUNT*KEEP_W-1:0]   axis_s_tkeep,
    input  logic [CH_COUNT-1:0]          axis_s_tvalid,
    input  logic [CH_COUNT-1:0]          axis_s_tlast,
    input  logic                         axis_m_tready,
    output logic [DATA_W-1:0]            axis_m_tdata,
    output logic [KEEP_W-1:0]            axis_m_tkeep,
    output logic                         axis_m_tvalid,
    output logic                         axis_m_tlast,
    output logic [SEL_W-1:0]             cur_ch,
    output logic                         busy,
    output logic [15:0]                  pkt_cnt
);

    // Handshake: a beat moves when valid and ready are both high at a rising
    // clk edge; valid never waits on ready, and a presented beat stays stable
    // until it is taken.
    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      cur_ch_q, cur_ch_d;
    logic [SEL_W-1:0]      last_grant_q, last_grant_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0]     m_data_q, m_data_d;
    logic [KEEP_W-1:0]     m_keep_q, m_keep_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;

    logic [CH_COUNT-1:0]   req;
    logic [2*CH_COUNT-1:0] req_dup;
    logic [CH_COUNT-1:0]   req_rot;
    int                    rr_start;
    int                    rr_pos;
    logic                  grant_vld;
    logic [SEL_W-1:0]      grant_ch;

    logic [DATA_W-1:0]     cur_data;
    logic [KEEP_W-1:0]     cur_keep;
    logic                  cur_valid;
    logic                  cur_last;
    logic                  cur_ready;
    logic                  accept;

    assign req       = axis_s_tvalid & ch_mask;
    assign cur_ready = axis_m_tready | ~m_valid_q;

    // Round-robin rotates the request vector so bit 0 is the channel after
    // last_grant; the lowest set bit of the rotated vector wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        req_dup   = {req, req};
        req_rot   = '0;
        rr_start  = 0;
        rr_pos    = 0;
        if (!mode) begin
            for (int k = 0; k < CH_COUNT; k++) begin
                if (sel == SEL_W'(k) && req[k]) begin
                    grant_vld = 1'b1;
                    grant_ch  = SEL_W'(k);
                end
            end
        end else begin
            rr_start = int'(last_grant_q) + 1;
            req_rot  = CH_COUNT'(req_dup >> rr_start);
            for (int j = CH_COUNT - 1; j >= 0; j--) begin
                if (req_rot[j]) begin
                    grant_vld = 1'b1;
                    rr_pos    = rr_start + j;
                end
            end
            if (rr_pos >= CH_COUNT) begin
                rr_pos = rr_pos - CH_COUNT;
            end
            grant_ch = SEL_W'(rr_pos);
        end
    end

    always_comb begin
        cur_data  = '0;
        cur_keep  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        for (int k = 0; k < CH_COUNT; k++) begin
            if (cur_ch_q == SEL_W'(k)) begin
                cur_data  = axis_s_tdata[k*DATA_W +: DATA_W];
                cur_keep  = axis_s_tkeep[k*KEEP_W +: KEEP_W];
                cur_valid = axis_s_tvalid[k];
                cur_last  = axis_s_tlast[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_ch_q     <= '0;
            last_grant_q <= SEL_W'(CH_COUNT - 1);
            pkt_cnt_q    <= '0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_ch_q     <= cur_ch_d;
            last_grant_q <= last_grant_d;
            pkt_cnt_q    <= pkt_cnt_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_ch_d     = cur_ch_q;
        last_grant_d = last_grant_q;
        pkt_cnt_d    = pkt_cnt_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        accept       = 1'b0;
        if (m_valid_q && axis_m_tready) begin
            m_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    cur_ch_d = grant_ch;
                    state_d  = XFER;
                end
            end
            XFER: begin
                accept = cur_valid & cur_ready;
                if (accept) begin
                    m_data_d  = cur_data;
                    m_keep_d  = cur_keep;
                    m_last_d  = cur_last;
                    m_valid_d = 1'b1;
                    if (cur_last) begin
                        state_d      = IDLE;
                        last_grant_d = cur_ch_q;
                        pkt_cnt_d    = pkt_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready and busy are forced low during reset even before the reset edge.
    always_comb begin
        axis_s_tready = '0;
        busy          = (state_q == XFER) && !rst;
        if (state_q == XFER && !rst) begin
            for (int k = 0; k < CH_COUNT; k++) begin
                if (cur_ch_q == SEL_W'(k)) begin
                    axis_s_tready[k] = cur_ready;
                end
            end
        end
    end

    assign axis_m_tdata  = m_data_q;
    assign axis_m_tkeep  = m_keep_q;
    assign axis_m_tvalid = m_valid_q;
    assign axis_m_tlast  = m_last_q;
    assign cur_ch        = cur_ch_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
